// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: default 640x480@60 timing constants,
// the BLACK colour value and the counter width helper.
package vga_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_PULSE   = 96;
    localparam int DEF_H_BACK    = 48;

    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_PULSE   = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int DEF_CLK_DIV   = 2;
    localparam int DEF_COLOR_W   = 1;
    localparam bit DEF_SYNC_POL  = 1'b0;

    // Colour value driven outside the visible area.
    localparam int unsigned BLACK = 0;

    // Bits needed to count 0..n-1; never less than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical): a wrapping position counter
// with visible-area and sync-pulse decode for the current position.
// Ports: clk, reset (sync, active-high), advance (step the counter),
//        count (current position), wrap (count is last position),
//        visible (count in visible area), sync (pulse at level POL).
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int VISIBLE = DEF_H_VISIBLE,
    parameter int FRONT   = DEF_H_FRONT,
    parameter int PULSE   = DEF_H_PULSE,
    parameter int BACK    = DEF_H_BACK,
    parameter bit POL     = DEF_SYNC_POL,
    localparam int TOTAL  = VISIBLE + FRONT + PULSE + BACK,
    localparam int W      = cnt_w(TOTAL)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         advance,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         visible,
    output logic         sync
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);
    localparam int unsigned  S_START = VISIBLE + FRONT;
    localparam int unsigned  S_END   = VISIBLE + FRONT + PULSE;

    // Decode in 32 bits so S_END == TOTAL cannot alias to 0.
    logic [31:0] pos;

    assign pos     = 32'(count);
    assign wrap    = (count == LAST);
    assign visible = (pos < VISIBLE);
    assign sync    = (pos >= S_START && pos < S_END) ? POL : ~POL;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (advance) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_generator.sv
// VGA raster timing: pixel-rate divider, column/row fetch coordinates,
// and a registered output stage (syncs, RGB, frame start) one pixel late.
// Ports: Clock, Reset (sync, active-high), Enable, iRed/iGreen/iBlue in;
//        oHorizontalSync, oVerticalSync, oRed/oGreen/oBlue, oColumnCount,
//        oRowCount, oRequest, oFrameStart out.
module vga_timing_generator
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_PULSE   = DEF_H_PULSE,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_PULSE   = DEF_V_PULSE,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int COLOR_W   = DEF_COLOR_W,
    parameter bit HSYNC_POL = DEF_SYNC_POL,
    parameter bit VSYNC_POL = DEF_SYNC_POL,
    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_PULSE + H_BACK,
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_PULSE + V_BACK,
    localparam int CW       = cnt_w(H_TOTAL),
    localparam int RW       = cnt_w(V_TOTAL)
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Enable,
    input  logic [COLOR_W-1:0] iRed,
    input  logic [COLOR_W-1:0] iGreen,
    input  logic [COLOR_W-1:0] iBlue,
    output logic               oHorizontalSync,
    output logic               oVerticalSync,
    output logic [COLOR_W-1:0] oRed,
    output logic [COLOR_W-1:0] oGreen,
    output logic [COLOR_W-1:0] oBlue,
    output logic [CW-1:0]      oColumnCount,
    output logic [RW-1:0]      oRowCount,
    output logic               oRequest,
    output logic               oFrameStart
);

    localparam int              DW       = cnt_w(CLK_DIV);
    localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [COLOR_W-1:0] BLK   = COLOR_W'(BLACK);

    logic [DW-1:0] div_cnt;
    logic          tick;
    logic          h_wrap;
    logic          v_wrap;
    logic          h_vis;
    logic          v_vis;
    logic          h_sync;
    logic          v_sync;

    // A tick marks the last clock of a pixel period; Enable low freezes
    // the divider so resuming never drops or repeats a pixel.
    assign tick = Enable && (div_cnt == DIV_LAST);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            div_cnt <= '0;
        end else if (Enable) begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .PULSE   (H_PULSE),
        .BACK    (H_BACK),
        .POL     (HSYNC_POL)
    ) u_h (
        .clk     (Clock),
        .reset   (Reset),
        .advance (tick),
        .count   (oColumnCount),
        .wrap    (h_wrap),
        .visible (h_vis),
        .sync    (h_sync)
    );

    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .PULSE   (V_PULSE),
        .BACK    (V_BACK),
        .POL     (VSYNC_POL)
    ) u_v (
        .clk     (Clock),
        .reset   (Reset),
        .advance (tick && h_wrap),
        .count   (oRowCount),
        .wrap    (v_wrap),
        .visible (v_vis),
        .sync    (v_sync)
    );

    // During reset the counters are heading to (0,0), which is visible.
    assign oRequest = Reset || (h_vis && v_vis);

    // Output stage samples the decode of the coordinate being left, so it
    // trails the fetch coordinate by one pixel; RGB read data for that
    // coordinate has had the whole pixel period to arrive.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            oHorizontalSync <= ~HSYNC_POL;
            oVerticalSync   <= ~VSYNC_POL;
            oRed            <= BLK;
            oGreen          <= BLK;
            oBlue           <= BLK;
            oFrameStart     <= 1'b0;
        end else begin
            oFrameStart <= tick && h_wrap && v_wrap;
            if (tick) begin
                oHorizontalSync <= h_sync;
                oVerticalSync   <= v_sync;
                if (oRequest) begin
                    oRed   <= iRed;
                    oGreen <= iGreen;
                    oBlue  <= iBlue;
                end else begin
                    oRed   <= BLK;
                    oGreen <= BLK;
                    oBlue  <= BLK;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Randomised bench for vga_timing_generator on a small raster; a
// pixel-index reference model predicts every output on every cycle.
module tb_vga_timing_generator;

    localparam int HV = 12, HF = 3, HP = 4, HB = 5;
    localparam int VV = 6, VF = 2, VP = 3, VB = 2;
    localparam int DIV = 3;
    localparam int CWID = 2;
    localparam bit HPOL = 1'b1;
    localparam bit VPOL = 1'b0;
    localparam int HT = HV + HF + HP + HB;
    localparam int VT = VV + VF + VP + VB;
    localparam int CW = $clog2(HT);
    localparam int RW = $clog2(VT);

    logic            Clock = 1'b0;
    logic            Reset = 1'b1;
    logic            Enable = 1'b0;
    logic [CWID-1:0] iRed = '0, iGreen = '0, iBlue = '0;
    logic            oHorizontalSync, oVerticalSync;
    logic [CWID-1:0] oRed, oGreen, oBlue;
    logic [CW-1:0]   oColumnCount;
    logic [RW-1:0]   oRowCount;
    logic            oRequest, oFrameStart;

    vga_timing_generator #(
        .H_VISIBLE (HV), .H_FRONT (HF), .H_PULSE (HP), .H_BACK (HB),
        .V_VISIBLE (VV), .V_FRONT (VF), .V_PULSE (VP), .V_BACK (VB),
        .CLK_DIV   (DIV), .COLOR_W (CWID),
        .HSYNC_POL (HPOL), .VSYNC_POL (VPOL)
    ) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .Enable          (Enable),
        .iRed            (iRed),
        .iGreen          (iGreen),
        .iBlue           (iBlue),
        .oHorizontalSync (oHorizontalSync),
        .oVerticalSync   (oVerticalSync),
        .oRed            (oRed),
        .oGreen          (oGreen),
        .oBlue           (oBlue),
        .oColumnCount    (oColumnCount),
        .oRowCount       (oRowCount),
        .oRequest        (oRequest),
        .oFrameStart     (oFrameStart)
    );

    always #5 Clock = ~Clock;

    int compared = 0;
    int mismatched = 0;

    // Model: enabled clocks since reset; pixel index = ecount / DIV.
    int              ecount = 0;
    bit              m_hs, m_vs, m_fs;
    logic [CWID-1:0] m_r, m_g, m_b;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_range(input int p, input int lo, input int n);
        return (p >= lo) && (p < lo + n);
    endfunction

    task automatic step(input bit en, input bit rst);
        int n, pc, pr, c, r;
        Enable = en;
        Reset  = rst;
        iRed   = CWID'($urandom);
        iGreen = CWID'($urandom);
        iBlue  = CWID'($urandom);
        @(posedge Clock);
        m_fs = 1'b0;
        if (rst) begin
            ecount = 0;
            m_hs = !HPOL;
            m_vs = !VPOL;
            m_r = '0; m_g = '0; m_b = '0;
        end else if (en) begin
            ecount++;
            if (ecount % DIV == 0) begin
                n  = ecount / DIV;
                pc = (n - 1) % HT;
                pr = ((n - 1) / HT) % VT;
                m_hs = in_range(pc, HV + HF, HP) ? HPOL : !HPOL;
                m_vs = in_range(pr, VV + VF, VP) ? VPOL : !VPOL;
                if (pc < HV && pr < VV) begin
                    m_r = iRed; m_g = iGreen; m_b = iBlue;
                end else begin
                    m_r = '0; m_g = '0; m_b = '0;
                end
                m_fs = (n % (HT * VT) == 0);
            end
        end
        #1;
        n = ecount / DIV;
        c = n % HT;
        r = (n / HT) % VT;
        chk("col", 32'(oColumnCount), c);
        chk("row", 32'(oRowCount), r);
        chk("req", 32'(oRequest), 32'(rst || (c < HV && r < VV)));
        chk("hsync", 32'(oHorizontalSync), 32'(m_hs));
        chk("vsync", 32'(oVerticalSync), 32'(m_vs));
        chk("red", 32'(oRed), 32'(m_r));
        chk("green", 32'(oGreen), 32'(m_g));
        chk("blue", 32'(oBlue), 32'(m_b));
        chk("fstart", 32'(oFrameStart), 32'(m_fs));
    endtask

    initial begin
        int cnt;
        bit found;

        // Reset state, held a few cycles.
        repeat (3) step(1'b1, 1'b1);

        // First tick DIV cycles after release.
        repeat (DIV - 1) step(1'b1, 1'b0);
        chk("first_tick_pre", 32'(oColumnCount), 0);
        step(1'b1, 1'b0);
        chk("first_tick", 32'(oColumnCount), 1);

        // Free run to a frame start.
        found = 0;
        for (int i = 0; i < 2 * HT * VT * DIV && !found; i++) begin
            step(1'b1, 1'b0);
            found = oFrameStart;
        end
        chk("wait_frame", 32'(found), 1);
        chk("frame_col", 32'(oColumnCount), 0);
        chk("frame_row", 32'(oRowCount), 0);

        // Sync pulse widths and frame period, in clocks.
        cnt = 0;
        for (int i = 0; i < HT * DIV; i++) begin
            step(1'b1, 1'b0);
            if (oHorizontalSync == HPOL) cnt++;
        end
        chk("hs_clocks", cnt, HP * DIV);
        cnt = 0;
        found = 0;
        for (int i = 0; i < 2 * HT * VT * DIV && !found; i++) begin
            step(1'b1, 1'b0);
            if (oVerticalSync == VPOL) cnt++;
            found = oFrameStart;
        end
        chk("vs_clocks", cnt, VP * HT * DIV);
        chk("frame_period", compared > 0 ? ecount : -1, 2 * HT * VT * DIV);

        // Freeze mid-line.
        found = 0;
        for (int i = 0; i < HT * DIV + 1 && !found; i++) begin
            step(1'b1, 1'b0);
            found = (oColumnCount == CW'(5));
        end
        chk("wait_col5", 32'(found), 1);
        repeat (10) step(1'b0, 1'b0);
        chk("frozen_col", 32'(oColumnCount), 5);
        repeat (DIV) step(1'b1, 1'b0);
        chk("resume_col", 32'(oColumnCount), 6);

        // Reset while inside both sync pulses.
        found = 0;
        for (int i = 0; i < 2 * HT * VT * DIV && !found; i++) begin
            step(1'b1, 1'b0);
            found = (oRowCount == RW'(8)) && (oColumnCount == CW'(16));
        end
        chk("wait_r8c16", 32'(found), 1);
        step(1'b1, 1'b1);
        chk("rst_hs", 32'(oHorizontalSync), 32'(!HPOL));
        chk("rst_col", 32'(oColumnCount), 0);

        // Random enable with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 599) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/vga_timing_generator.md
VGA_TIMING_GENERATOR -- requirements
Module: vga_timing_generator

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch, in pixels
- H_PULSE, 96, hsync width, in pixels
- H_BACK, 48, horizontal back porch, in pixels
- V_VISIBLE, 480, visible lines
- V_FRONT, 10, vertical front porch, in lines
- V_PULSE, 2, vsync width, in lines
- V_BACK, 33, vertical back porch, in lines
- CLK_DIV, 2, Clock cycles per pixel (>=1)
- COLOR_W, 1, bits per colour channel
- HSYNC_POL, 0, active level of hsync
- VSYNC_POL, 0, active level of vsync
REQ-002 Ports SHALL be (name, direction, width, meaning):
- Clock, in, 1, sole clock
- Reset, in, 1, synchronous, active-high
- Enable, in, 1, advance timing when high
- iRed/iGreen/iBlue, in, COLOR_W each, pixel data for the last requested coordinate
- oHorizontalSync, out, 1, hsync
- oVerticalSync, out, 1, vsync
- oRed/oGreen/oBlue, out, COLOR_W each, colour
- oColumnCount, out, CW, fetch column
- oRowCount, out, RW, fetch row
- oRequest, out, 1, fetch coordinate is visible
- oFrameStart, out, 1, one-Clock pulse at pixel (0,0)
REQ-003 CW SHALL be $clog2(H_TOTAL) and RW SHALL be $clog2(V_TOTAL), where H_TOTAL = sum of all H_* parameters and V_TOTAL = sum of all V_* parameters.

Function
REQ-004 A divider SHALL assert an internal pixel tick once every CLK_DIV Clock cycles while Enable=1; CLK_DIV=1 SHALL tick every cycle.
REQ-005 The column counter SHALL advance on each tick and wrap from H_TOTAL-1 to 0; the row counter SHALL advance only when the column wraps and SHALL wrap from V_TOTAL-1 to 0.
REQ-006 oColumnCount/oRowCount SHALL equal the counters directly; oRequest SHALL be 1 iff column<H_VISIBLE and row<V_VISIBLE.
REQ-007 Output stage, registered on each tick, one pixel period behind the fetch coordinate:
- hsync SHALL be active iff H_VISIBLE+H_FRONT <= column < H_VISIBLE+H_FRONT+H_PULSE, giving exactly H_PULSE pixels.
- vsync SHALL be active iff V_VISIBLE+V_FRONT <= row < V_VISIBLE+V_FRONT+V_PULSE, giving exactly V_PULSE lines.
REQ-008 RGB SHALL be captured from iRed/iGreen/iBlue on the tick following a tick with oRequest=1, and SHALL be all-zero otherwise. Input data therefore has CLK_DIV cycles of read latency budget.
REQ-009 oFrameStart SHALL pulse for exactly one Clock, on the tick cycle in which the counters move to (0,0).
REQ-010 With Enable=0, the divider, counters and all outputs SHALL hold their values; resuming SHALL continue without skipping a pixel.
REQ-011 Simultaneous column and row wrap SHALL yield (0,0) and oFrameStart in the same cycle.

Reset
REQ-012 On Reset=1 at a Clock edge, the following SHALL occur:
- divider, counters, oColumnCount and oRowCount go to 0
- syncs go to their inactive level
- RGB goes to 0
- oFrameStart goes to 0
REQ-013 Reset SHALL take priority over Enable. After release, the first tick SHALL occur CLK_DIV cycles later.
REQ-014 oRequest SHALL be 1 during reset, since (0,0) is visible.

Structure
REQ-015 Default timing constants, the BLACK colour constant, and a width helper SHALL live in shared package vga_pkg.
REQ-016 One sub-module, vga_axis_counter, SHALL be instantiated twice (horizontal, vertical). It SHALL take parameters VISIBLE/FRONT/PULSE/BACK/POL and provide count, wrap, visible and sync.

Verification
REQ-017 Defaults, free run -> hsync active 192 Clocks, period 1600 Clocks; vsync active 3200 Clocks, period 840000 Clocks.
REQ-018 H=4/1/1/2, V=3/1/1/1, CLK_DIV=1 -> columns 0..7 repeat; hsync active at the output stage one cycle after column 5; oFrameStart every 48 cycles.
REQ-019 iRed=1 held; row 0 columns 639→640 -> oRed=1 for output pixel 639; oRed=0 from pixel 640 onward.
REQ-020 Enable low for 10 cycles mid-line at column 100 -> counters frozen at 100, outputs unchanged, then column 101 follows after resume.
REQ-021 Reset asserted at row 300, column 500 -> next cycle counters 0/0, syncs inactive, RGB 0; first tick CLK_DIV cycles after release.
REQ-022 HSYNC_POL=1 -> hsync high only during the 96-pixel pulse.
